// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the cascaded PLL power-up sequencer.
// Default timing assumes the 50 MHz board clock.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_e;

  localparam int DEF_N_STAGES      = 4;
  localparam int DEF_HOLD_CYCLES   = 500;    // 10 us
  localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms
  localparam int DEF_STABLE_CYCLES = 1000;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_AUTO_START    = 1;

  // One shared timer is wide enough to hold the largest interval it measures.
  function automatic int timer_width(input int hold_c, input int lock_c, input int stable_c);
    int m;
    m = hold_c;
    if (lock_c > m) m = lock_c;
    if (stable_c > m) m = stable_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_vec.sv
// Two-flop synchronizer for a vector of independent asynchronous flags.
// Each bit is synchronized on its own; no coherency between bits is implied.
module sync_vec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_seq_ctrl.sv
// Power-up and recovery sequencer for a cascaded PLL chain: releases each stage's
// reset in order, waits for lock with timeout/retry, and re-sequences on lock loss.
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int N_STAGES      = DEF_N_STAGES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int AUTO_START    = DEF_AUTO_START
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                start,
  input  logic [N_STAGES-1:0] pll_locked,
  output logic [N_STAGES-1:0] pll_rst,
  output logic [N_STAGES-1:0] stage_ready,
  output logic                all_ready,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_stage,
  output logic [1:0]          retry_cnt
);

  localparam int TW = timer_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    LAST_STAGE  = 2'(N_STAGES - 1);

  seq_state_e          state, state_n;
  logic [1:0]          k, k_n;
  logic [TW-1:0]       timer, timer_n;
  logic [1:0]          retry_n;
  logic [N_STAGES-1:0] pll_rst_n, ready_n;
  logic [N_STAGES-1:0] lk, loss, keep;
  logic [1:0]          loss_j;
  logic                sequencing;

  sync_vec #(.WIDTH(N_STAGES)) u_lock_sync (
    .clk   (clk_50MHz),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (lk)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    k_n       = k;
    timer_n   = (timer == '1) ? timer : timer + 1'b1;
    retry_n   = retry_cnt;
    pll_rst_n = pll_rst;
    ready_n   = stage_ready;

    // An accepted stage that loses lock forces a restart from the lowest such stage.
    loss   = stage_ready & ~lk;
    loss_j = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (loss[i]) loss_j = 2'(i);
    end
    for (int i = 0; i < N_STAGES; i++) begin
      keep[i] = (i < int'(loss_j));
    end
    sequencing = (state == HOLD) || (state == WAIT_LOCK) || (state == STABLE) || (state == RUN);

    if (sequencing && (|loss)) begin
      state_n   = HOLD;
      k_n       = loss_j;
      timer_n   = '0;
      retry_n   = '0;
      ready_n   = stage_ready & keep;
      pll_rst_n = pll_rst | ~keep;
    end else begin
      unique case (state)
        IDLE: begin
          if (start || (AUTO_START != 0)) begin
            state_n = HOLD;
            timer_n = '0;
          end
        end
        HOLD: begin
          if (timer == HOLD_LAST) begin
            pll_rst_n[k] = 1'b0;
            state_n      = WAIT_LOCK;
            timer_n      = '0;
          end
        end
        WAIT_LOCK: begin
          if (lk[k]) begin
            state_n = STABLE;
            timer_n = '0;
          end else if (timer == LOCK_LAST) begin
            pll_rst_n[k] = 1'b1;
            timer_n      = '0;
            if (retry_cnt == 2'(MAX_RETRY)) begin
              state_n = FAIL;
            end else begin
              retry_n = retry_cnt + 2'd1;
              state_n = HOLD;
            end
          end
        end
        STABLE: begin
          if (!lk[k]) begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end else if (timer == STABLE_LAST) begin
            ready_n[k] = 1'b1;
            retry_n    = '0;
            timer_n    = '0;
            if (k == LAST_STAGE) begin
              state_n = RUN;
            end else begin
              k_n     = k + 2'd1;
              state_n = HOLD;
            end
          end
        end
        RUN: begin
        end
        FAIL: begin
          ready_n = stage_ready & lk;
          if (start) begin
            state_n   = HOLD;
            k_n       = '0;
            timer_n   = '0;
            retry_n   = '0;
            ready_n   = '0;
            pll_rst_n = '1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      pll_rst     <= '1;
      stage_ready <= '0;
      all_ready   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      err_stage   <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      timer       <= timer_n;
      retry_cnt   <= retry_n;
      pll_rst     <= pll_rst_n;
      stage_ready <= ready_n;
      all_ready   <= (state_n == RUN);
      busy        <= (state_n == HOLD) || (state_n == WAIT_LOCK) || (state_n == STABLE);
      err         <= (state_n == FAIL);
      err_stage   <= (state_n == FAIL) ? k_n : 2'd0;
    end
  end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Self-checking bench for pll_seq_ctrl: directed scenarios with randomized PLL lock
// latencies, compared every cycle against a timestamp-based behavioural model.
module tb_pll_seq_ctrl;

  localparam int N  = 4;
  localparam int HC = 4;
  localparam int LT = 20;
  localparam int SC = 3;
  localparam int MR = 2;

  logic         clk_50MHz = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] pll_locked = '0;
  logic [N-1:0] pll_rst, stage_ready;
  logic         all_ready, busy, err;
  logic [1:0]   err_stage, retry_cnt;

  pll_seq_ctrl #(
    .N_STAGES(N), .HOLD_CYCLES(HC), .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC), .MAX_RETRY(MR), .AUTO_START(1)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .start       (start),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .stage_ready (stage_ready),
    .all_ready   (all_ready),
    .busy        (busy),
    .err         (err),
    .err_stage   (err_stage),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: phase plus the edge count at which the phase was entered.
  typedef enum int {M_IDLE, M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAILED} phase_e;
  phase_e       ph;
  int           cyc, t0, k_m, retry_m;
  logic [N-1:0] acc, s1, s2;

  // PLL behaviour: lock rises dly cycles after reset falls unless suppressed.
  int           cnt [N];
  int           dly [N];
  logic [N-1:0] never, glitch;
  logic         arm_stable_glitch;

  function automatic logic [N-1:0] model_rst();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      case (ph)
        M_RUN:            r[i] = 1'b0;
        M_WAIT, M_STABLE: r[i] = (i > k_m);
        default:          r[i] = (i >= k_m);
      endcase
    end
    return r;
  endfunction

  task automatic enter(input phase_e p);
    ph = p;
    t0 = cyc;
  endtask

  task automatic init_model();
    ph = M_IDLE; cyc = 0; t0 = 0; k_m = 0; retry_m = 0;
    acc = '0; s1 = '0; s2 = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  task automatic model_edge(input logic st, input logic [N-1:0] raw);
    logic [N-1:0] lkm, loss;
    int j;
    cyc++;
    lkm  = s2;
    loss = acc & ~lkm;
    j = 0;
    for (int i = N - 1; i >= 0; i--) if (loss[i]) j = i;
    if ((ph inside {M_HOLD, M_WAIT, M_STABLE, M_RUN}) && loss != '0) begin
      for (int i = j; i < N; i++) acc[i] = 1'b0;
      k_m = j; retry_m = 0;
      enter(M_HOLD);
    end else begin
      case (ph)
        M_IDLE:   enter(M_HOLD);
        M_HOLD:   if (cyc - t0 == HC) enter(M_WAIT);
        M_WAIT: begin
          if (lkm[k_m]) enter(M_STABLE);
          else if (cyc - t0 == LT) begin
            if (retry_m == MR) enter(M_FAILED);
            else begin retry_m++; enter(M_HOLD); end
          end
        end
        M_STABLE: begin
          if (!lkm[k_m]) enter(M_WAIT);
          else if (cyc - t0 == SC) begin
            acc[k_m] = 1'b1; retry_m = 0;
            if (k_m == N - 1) enter(M_RUN);
            else begin k_m++; enter(M_HOLD); end
          end
        end
        M_RUN: ;
        M_FAILED: begin
          acc = acc & lkm;
          if (st) begin acc = '0; k_m = 0; retry_m = 0; enter(M_HOLD); end
        end
        default: ;
      endcase
    end
    s2 = s1;
    s1 = raw;
  endtask

  task automatic compare_all();
    check("pll_rst", pll_rst, model_rst());
    check("stage_ready", stage_ready, acc);
    check("all_ready", all_ready, ph == M_RUN);
    check("busy", busy, ph inside {M_HOLD, M_WAIT, M_STABLE});
    check("err", err, ph == M_FAILED);
    check("err_stage", err_stage, (ph == M_FAILED) ? k_m : 0);
    check("retry_cnt", retry_cnt, retry_m);
  endtask

  task automatic drive_plls();
    logic [N-1:0] r, raw;
    r = model_rst();
    if (arm_stable_glitch && ph == M_STABLE && k_m == 0) begin
      glitch[0] = 1'b1;
      arm_stable_glitch = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (r[i]) cnt[i] = 0;
      else if (cnt[i] < 1000) cnt[i]++;
      raw[i] = !never[i] && !glitch[i] && (cnt[i] > dly[i]);
    end
    pll_locked = raw;
    glitch = '0;
  endtask

  task automatic tick();
    logic st;
    logic [N-1:0] raw;
    st  = start;
    raw = pll_locked;
    @(posedge clk_50MHz);
    #1;
    model_edge(st, raw);
    compare_all();
    drive_plls();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    init_model();
    pll_locked = '0;
    #1;
    compare_all();
    @(posedge clk_50MHz);
    #1;
    rst = 1'b1;
  endtask

  task automatic randomize_delays();
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 8);
  endtask

  initial begin
    logic [N-1:0] prev;
    logic [31:0]  order, rseq;
    logic [1:0]   prev_retry;
    never = '0; glitch = '0; arm_stable_glitch = 1'b0;
    for (int i = 0; i < N; i++) dly[i] = 5;

    // Reset state and clean bring-up with 5-cycle lock latency.
    #2;
    do_reset();
    check("reset_pll_rst", pll_rst, 4'b1111);
    check("reset_ready", stage_ready, 4'b0000);
    prev = pll_rst; order = 0;
    for (int n = 0; n < 300 && ph != M_RUN; n++) begin
      tick();
      for (int i = 0; i < N; i++) if (prev[i] && !pll_rst[i]) order = (order << 4) | i;
      prev = pll_rst;
    end
    check("bringup_fall_order", order, 32'h0123);
    check("bringup_all_ready", all_ready, 1'b1);
    check("bringup_err", err, 1'b0);
    check("bringup_pll_rst", pll_rst, 4'b0000);

    // start is ignored while running.
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("run_start_ignored", all_ready, 1'b1);

    // One-cycle lock loss on stage 2 in RUN.
    dly[2] = $urandom_range(1, 8); dly[3] = $urandom_range(1, 8);
    glitch = 4'b0100;
    for (int n = 0; n < 4; n++) tick();
    check("runloss_ready", stage_ready, 4'b0011);
    check("runloss_pll_rst", pll_rst, 4'b1100);
    check("runloss_all_ready", all_ready, 1'b0);
    check("runloss_retry", retry_cnt, 2'd0);
    for (int n = 0; n < 300 && ph != M_RUN; n++) tick();
    check("runloss_recovered", all_ready, 1'b1);

    // Lock glitch on stage 0 while it is being qualified.
    randomize_delays();
    do_reset();
    arm_stable_glitch = 1'b1;
    for (int n = 0; n < 100 && !(ph == M_STABLE && k_m == 0); n++) tick();
    for (int n = 0; n < 10 && ph != M_WAIT; n++) tick();
    check("stglitch_retry", retry_cnt, 2'd0);
    check("stglitch_ready", stage_ready, 4'b0000);
    check("stglitch_busy", busy, 1'b1);
    check("stglitch_pll_rst", pll_rst, 4'b1110);
    for (int n = 0; n < 50 && acc[0] == 1'b0; n++) tick();
    check("stglitch_accepted", stage_ready[0], 1'b1);

    // Stage 1 never locks: two retries then FAIL.
    randomize_delays();
    never = 4'b0010;
    do_reset();
    rseq = 0; prev_retry = retry_cnt;
    for (int n = 0; n < 400 && ph != M_FAILED; n++) begin
      tick();
      if (retry_cnt != prev_retry && retry_cnt != 2'd0) rseq = (rseq << 4) | retry_cnt;
      prev_retry = retry_cnt;
    end
    check("timeout_retry_seq", rseq, 32'h12);
    check("timeout_err", err, 1'b1);
    check("timeout_err_stage", err_stage, 2'd1);
    check("timeout_pll_rst_hi", pll_rst[3:1], 3'b111);
    check("timeout_ready", stage_ready, 4'b0001);
    check("timeout_retry", retry_cnt, 2'd2);

    // Recovery from FAIL with start.
    never = '0;
    for (int n = 0; n < 5; n++) tick();
    check("fail_sticky", err, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check("recover_err", err, 1'b0);
    check("recover_pll_rst", pll_rst, 4'b1111);
    check("recover_retry", retry_cnt, 2'd0);
    for (int n = 0; n < 300 && ph != M_RUN; n++) tick();
    check("recover_all_ready", all_ready, 1'b1);

    // Asynchronous reset during WAIT_LOCK of stage 2.
    randomize_delays();
    do_reset();
    for (int n = 0; n < 200 && !(ph == M_WAIT && k_m == 2); n++) tick();
    check("areset_reached_stage2", pll_rst, 4'b1000);
    #3;
    rst = 1'b0;
    #1;
    check("areset_pll_rst", pll_rst, 4'b1111);
    check("areset_ready", stage_ready, 4'b0000);
    check("areset_all_ready", all_ready, 1'b0);
    check("areset_busy", busy, 1'b0);
    check("areset_err", err, 1'b0);
    check("areset_err_stage", err_stage, 2'd0);
    check("areset_retry", retry_cnt, 2'd0);
    do_reset();
    for (int n = 0; n < 300 && ph != M_RUN; n++) tick();
    check("after_reset_all_ready", all_ready, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
- Power-up and recovery sequencer for the four-stage cascaded PLL chain (50 MHz -> 500 kHz -> 5 kHz -> 50 Hz -> 0.5 Hz).
- Each stage's refclk is the previous stage's output, so the stages are brought up in order. The block holds each stage's PLL reset, releases it, waits for lock with a timeout, requires lock stability, then moves to the next stage.
- Runs on the free-running 50 MHz board clock. Re-sequences from the failing stage when lock is lost.

Parameters:
- N_STAGES, 4, number of cascaded PLL stages.
- HOLD_CYCLES, 500, cycles pll_rst is held high before release (10 us).
- LOCK_TIMEOUT, 50000, cycles allowed from release to lock (1 ms).
- STABLE_CYCLES, 1000, cycles of continuous synchronized lock needed to accept a stage.
- MAX_RETRY, 3, timeouts allowed per stage before FAIL.
- AUTO_START, 1, 1 = leave IDLE automatically after reset.

Ports:
- clk_50MHz  in  1  free-running reference clock; all logic runs on it.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts the sequence from IDLE, or restarts it from FAIL.
- pll_locked  in  N_STAGES  raw lock flags from the PLLs; asynchronous.
- pll_rst  out  N_STAGES  active-high reset to each PLL stage.
- stage_ready  out  N_STAGES  bit k high when stage k is accepted and still locked.
- all_ready  out  1  all stages ready; state is RUN.
- busy  out  1  state is HOLD, WAIT_LOCK or STABLE.
- err  out  1  sticky in FAIL.
- err_stage  out  2  index of the failing stage.
- retry_cnt  out  2  timeouts counted on the current stage.

Behaviour:
- Reset (rst=0), asynchronous:
  - pll_rst = all ones; every other output = 0.
  - State IDLE; cur stage k = 0; all counters = 0.
- Lock synchronization: pll_locked passes through a 2-flop synchronizer. The FSM sees lock 2 cycles after the raw edge.
- IDLE:
  - Transition to HOLD when start=1, or on the first cycle after reset if AUTO_START=1.
  - Load timer = 0.
- HOLD:
  - pll_rst[k..N-1] = 1; timer counts up.
  - At timer == HOLD_CYCLES-1: pll_rst[k] <= 0 next cycle, then WAIT_LOCK with timer cleared.
- WAIT_LOCK:
  - Synchronized lock[k]=1 -> STABLE, timer cleared.
  - Timer reaching LOCK_TIMEOUT-1 without lock -> retry_cnt++, back to HOLD (pll_rst[k] re-asserted).
  - If retry_cnt already equals MAX_RETRY -> FAIL instead.
- STABLE:
  - Lock[k] drop before timer reaches STABLE_CYCLES-1 -> WAIT_LOCK. The WAIT_LOCK timer restarts from 0; no retry counted.
  - Stable for STABLE_CYCLES -> stage_ready[k]=1, retry_cnt=0, then:
    - k < N-1: k++ and go to HOLD (downstream pll_rst stays high throughout).
    - k == N-1: go to RUN.
- RUN:
  - all_ready=1; all pll_rst low.
  - On loss of synchronized lock in any stage j, take the lowest such j and, in the next cycle:
    - stage_ready[j..N-1] = 0; pll_rst[j..N-1] = 1; k = j; state HOLD.
  - all_ready drops on that same edge.
- FAIL:
  - err=1; err_stage=k; pll_rst[k..N-1]=1; stage_ready of lower stages remains per live lock.
  - start clears err and retry_cnt, sets k=0, and goes to HOLD with all pll_rst=1.
- Lost lock in a lower stage during sequencing (HOLD, WAIT_LOCK or STABLE of stage k, with lock[j] dropping for j<k):
  - Handled exactly as the RUN loss: restart from j.
  - This takes priority over the stage-k timeout when both occur in the same cycle.
- start is ignored in HOLD, WAIT_LOCK, STABLE and RUN.
- Timer width: clog2(max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). It saturates and never wraps.
- All outputs are registered.

Decomposition:
- Package pll_seq_pkg holds:
  - state encodings IDLE, HOLD, WAIT_LOCK, STABLE, RUN, FAIL (3-bit);
  - default timing constants;
  - the timer-width function.
- One sub-module, sync_vec: a parameterized-width 2-flop synchronizer for pll_locked, with async active-low reset to 0.

Test Plan:
Bench parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=3, MAX_RETRY=2, AUTO_START=1.
- Clean bring-up: after rst release, model each PLL asserting lock 5 cycles after its pll_rst falls -> pll_rst bits fall in order 0,1,2,3; all_ready=1 after ~4x(4+2+5+3) cycles; err=0.
- Timeout and retry: stage 1 never locks -> pll_rst[1] pulses high 4 cycles after every 20-cycle wait; retry_cnt steps 1, 2; third timeout gives err=1, err_stage=1, pll_rst[3:1]=3'b111, stage_ready=4'b0001.
- Recovery from FAIL: in the previous case, stage 1 locks normally, then start pulses -> err=0, full sequence reruns from stage 0, all_ready=1.
- Loss of lock in RUN: drop pll_locked[2] for 1 cycle -> 3 cycles later stage_ready=4'b0011, pll_rst=4'b1100, all_ready=0; stages 2 and 3 re-sequence; no retry counted.
- Lock glitch during STABLE: stage 0 lock drops after 1 stable cycle -> back to WAIT_LOCK with retry_cnt=0; stage accepted only after 3 continuous cycles.
- Async reset mid-sequence: rst=0 during WAIT_LOCK of stage 2 -> pll_rst=4'b1111 and all other outputs 0 immediately, without waiting for a clock edge.
